// File: rtl/wisc_pkg.sv
// rtl/wisc_pkg.sv - shared WISC opcode, condition-code and fetch FSM definitions
package wisc_pkg;

  localparam int INSTR_W = 16;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_XOR    = 4'h2;
  localparam logic [3:0] OP_RED    = 4'h3;
  localparam logic [3:0] OP_SRA    = 4'h4;
  localparam logic [3:0] OP_SLL    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_PADDSB = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LLB    = 4'hA;
  localparam logic [3:0] OP_LHB    = 4'hB;
  localparam logic [3:0] OP_B      = 4'hC;
  localparam logic [3:0] OP_BR     = 4'hD;
  localparam logic [3:0] OP_PCS    = 4'hE;
  localparam logic [3:0] OP_HLT    = 4'hF;

  localparam logic [2:0] CC_NE  = 3'b000;
  localparam logic [2:0] CC_EQ  = 3'b001;
  localparam logic [2:0] CC_GT  = 3'b010;
  localparam logic [2:0] CC_LT  = 3'b011;
  localparam logic [2:0] CC_GE  = 3'b100;
  localparam logic [2:0] CC_LE  = 3'b101;
  localparam logic [2:0] CC_OV  = 3'b110;
  localparam logic [2:0] CC_UNC = 3'b111;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_CAPT  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/branch_cond_eval.sv
// rtl/branch_cond_eval.sv - combinational branch condition evaluation from Z/V/N flags
module branch_cond_eval
  import wisc_pkg::*;
(
  input  logic [2:0] ccc,
  input  logic       z,
  input  logic       v,
  input  logic       n,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (ccc)
      CC_NE:   taken = !z;
      CC_EQ:   taken = z;
      CC_GT:   taken = !z && !n;
      CC_LT:   taken = n;
      CC_GE:   taken = z || (!z && !n);
      CC_LE:   taken = n || z;
      CC_OV:   taken = v;
      CC_UNC:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC holder and instruction fetch with valid/ready issue to decode
module instr_fetch_unit
  import wisc_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic               clk,
  input  logic               rst,
  output logic [15:0]        imem_addr,
  output logic               imem_re,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [15:0]        pc,
  output logic [15:0]        pc_plus2,
  input  logic               flag_z,
  input  logic               flag_v,
  input  logic               flag_n,
  input  logic [15:0]        br_reg_target,
  output logic               halted
);

  fetch_state_e state;
  logic [3:0]   opcode;
  logic         taken;
  logic [15:0]  br_offset;
  logic [15:0]  next_pc;
  logic         handshake;

  assign opcode    = instr[15:12];
  assign pc_plus2  = pc + 16'd2;
  assign imem_addr = pc;
  // The read strobe must be live in the very first cycle after reset releases.
  assign imem_re   = (state == ST_REQ) && !rst;
  assign handshake = (state == ST_ISSUE) && instr_ready;

  branch_cond_eval u_cond (
    .ccc   (instr[11:9]),
    .z     (flag_z),
    .v     (flag_v),
    .n     (flag_n),
    .taken (taken)
  );

  always_comb begin
    br_offset = {{6{instr[8]}}, instr[8:0], 1'b0};
    next_pc   = pc_plus2;
    case (opcode)
      OP_B:    if (taken) next_pc = pc_plus2 + br_offset;
      OP_BR:   if (taken) next_pc = br_reg_target;
      default: next_pc = pc_plus2;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_REQ;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        ST_REQ: begin
          state <= ST_CAPT;
        end
        ST_CAPT: begin
          instr       <= imem_rdata;
          instr_valid <= 1'b1;
          state       <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (handshake) begin
            instr_valid <= 1'b0;
            if (opcode == OP_HLT) begin
              halted <= 1'b1;
              state  <= ST_HALT;
            end else begin
              pc    <= next_pc;
              state <= ST_REQ;
            end
          end
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state <= ST_REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed scoreboard bench for instr_fetch_unit
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic [15:0] imem_addr;
  logic        imem_re;
  logic [15:0] imem_rdata;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic        flag_z, flag_v, flag_n;
  logic [15:0] br_reg_target;
  logic        halted;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] word;
    logic [15:0] nxt;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] mem [0:65535];
  int          checks;
  int          failures;
  int          re_count;

  instr_fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr),
    .imem_re       (imem_re),
    .imem_rdata    (imem_rdata),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .pc            (pc),
    .pc_plus2      (pc_plus2),
    .flag_z        (flag_z),
    .flag_v        (flag_v),
    .flag_n        (flag_n),
    .br_reg_target (br_reg_target),
    .halted        (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_re) imem_rdata <= mem[imem_addr];
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge while the DUT is in REQ (or about to fetch).
  task automatic step(input logic [15:0] a, input logic [15:0] w,
                      input logic z, input logic v, input logic n,
                      input logic [15:0] brt, input logic [15:0] nxt, input int stall);
    exp_t e;
    int   k;
    mem[a] = w;
    sb.push_back({a, w, nxt});
    k = 0;
    while (!instr_valid && k < 8) begin
      @(negedge clk);
      k++;
    end
    chk("valid_wait", 16'(instr_valid), 16'd1);
    e = sb.pop_front();
    chk("instr", instr, e.word);
    chk("pc", pc, e.addr);
    chk("pc_plus2", pc_plus2, e.addr + 16'd2);
    for (int i = 0; i < stall; i++) begin
      flag_z        = 1'($urandom);
      flag_v        = 1'($urandom);
      flag_n        = 1'($urandom);
      br_reg_target = 16'($urandom);
      @(negedge clk);
      chk("stall_instr", instr, e.word);
      chk("stall_pc", pc, e.addr);
      chk("stall_valid", 16'(instr_valid), 16'd1);
      chk("stall_re", 16'(imem_re), 16'd0);
    end
    flag_z        = z;
    flag_v        = v;
    flag_n        = n;
    br_reg_target = brt;
    instr_ready   = 1'b1;
    @(negedge clk);
    instr_ready   = 1'b0;
    if (w[15:12] == 4'hF) begin
      chk("hlt_pc", pc, e.addr);
      chk("hlt_halted", 16'(halted), 16'd1);
      chk("hlt_valid", 16'(instr_valid), 16'd0);
    end else begin
      chk("next_pc", pc, e.nxt);
      chk("refetch_re", 16'(imem_re), 16'd1);
      chk("refetch_addr", imem_addr, e.nxt);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    rst = 1'b1;
    instr_ready = 1'b0;
    flag_z = 1'b0;
    flag_v = 1'b0;
    flag_n = 1'b0;
    br_reg_target = 16'h0000;
    imem_rdata = 16'h0000;
    repeat (2) @(negedge clk);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_instr", instr, 16'h0000);
    chk("rst_valid", 16'(instr_valid), 16'd0);
    chk("rst_re", 16'(imem_re), 16'd0);
    chk("rst_halted", 16'(halted), 16'd0);

    // First fetch latency
    mem[16'h0000] = 16'h0123;
    rst = 1'b0;
    #1;
    chk("c1_re", 16'(imem_re), 16'd1);
    chk("c1_addr", imem_addr, 16'h0000);
    @(negedge clk);
    chk("c2_re", 16'(imem_re), 16'd0);
    chk("c2_valid", 16'(instr_valid), 16'd0);
    @(negedge clk);
    chk("c3_valid", 16'(instr_valid), 16'd1);
    step(16'h0000, 16'h0123, 0, 0, 0, 16'h0000, 16'h0002, 0);

    // B and BR
    step(16'h0002, 16'hCE06, 0, 0, 0, 16'h0000, 16'h0010, 0);
    step(16'h0010, 16'hCE05, 0, 0, 0, 16'h0000, 16'h001C, 0);
    step(16'h001C, 16'hDE30, 0, 0, 0, 16'h0010, 16'h0010, 0);
    step(16'h0010, 16'hC1FF, 0, 0, 0, 16'h0000, 16'h0010, 0);
    step(16'h0010, 16'hC1FF, 1, 0, 0, 16'h0000, 16'h0012, 0);
    step(16'h0012, 16'hCE06, 0, 0, 0, 16'h0000, 16'h0020, 0);
    step(16'h0020, 16'hDE30, 0, 0, 0, 16'h4000, 16'h4000, 0);
    step(16'h4000, 16'hDE30, 0, 0, 0, 16'h0020, 16'h0020, 0);
    step(16'h0020, 16'hD230, 0, 0, 1, 16'h4000, 16'h0022, 0);

    // Backpressure with flags toggling; only handshake flags matter (LT, N=0)
    step(16'h0022, 16'hC601, 0, 0, 0, 16'h0000, 16'h0024, 5);

    // HLT
    step(16'h0024, 16'hDE30, 0, 0, 0, 16'h0008, 16'h0008, 0);
    step(16'h0008, 16'hF000, 0, 0, 0, 16'h0000, 16'h0008, 0);
    re_count = 0;
    for (int i = 0; i < 20; i++) begin
      instr_ready = 1'($urandom);
      @(negedge clk);
      if (imem_re) re_count++;
    end
    instr_ready = 1'b0;
    chk("halt_no_re", 16'(re_count), 16'd0);
    chk("halt_pc_hold", pc, 16'h0008);
    chk("halt_sticky", 16'(halted), 16'd1);
    rst = 1'b1;
    #1;
    chk("halt_rst_pc", pc, 16'h0000);
    chk("halt_rst_halted", 16'(halted), 16'd0);
    @(negedge clk);
    rst = 1'b0;

    // Wrap
    step(16'h0000, 16'hDE30, 0, 0, 0, 16'hFFFE, 16'hFFFE, 0);
    step(16'hFFFE, 16'hCE00, 0, 0, 0, 16'h0000, 16'h0000, 0);

    // Reset during CAPT
    mem[16'h0000] = 16'h1234;
    @(negedge clk);
    chk("capt_instr_before", instr, 16'hCE00);
    rst = 1'b1;
    #1;
    chk("capt_rst_instr", instr, 16'h0000);
    chk("capt_rst_valid", 16'(instr_valid), 16'd0);
    chk("capt_rst_pc", pc, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("restart_re", 16'(imem_re), 16'd1);
    chk("restart_addr", imem_addr, 16'h0000);
    step(16'h0000, 16'h1234, 0, 0, 0, 16'h0000, 16'h0002, 0);

    // Remaining condition codes
    step(16'h0002, 16'hC801, 0, 0, 1, 16'h0000, 16'h0004, 0);
    step(16'h0004, 16'hCA01, 0, 0, 1, 16'h0000, 16'h0008, 0);
    step(16'h0008, 16'hCC01, 0, 1, 0, 16'h0000, 16'h000C, 0);
    step(16'h000C, 16'hC401, 0, 0, 0, 16'h0000, 16'h0010, 0);
    step(16'h0010, 16'hC001, 1, 0, 0, 16'h0000, 16'h0012, 0);
    step(16'h0012, 16'hE000, 0, 0, 0, 16'h0000, 16'h0014, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
